// File: rtl/mmcm_std_reconfig.sv
`default_nettype none
// ============================================================================
//  Module   : mmcm_std_reconfig
//  Purpose  : DRP read-modify-write sequencer that retunes the dot4x MMCM
//             between PAL and NTSC settings while holding it in reset.
//  Revision : 1.0 - initial release
// ============================================================================
module mmcm_std_reconfig #(
    parameter int                    NUM_REGS     = 8,
    parameter logic [NUM_REGS*39-1:0] PAL_TABLE   = '0,
    parameter logic [NUM_REGS*39-1:0] NTSC_TABLE  = '0,
    parameter int                    DRDY_TIMEOUT = 64,
    parameter int                    LOCK_TIMEOUT = 65535,
    parameter bit                    INIT_PAL     = 1'b1
) (
    input  logic        clk_in12mhz,
    input  logic        reset,
    input  logic        switch_req,
    input  logic        pal_sel,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    output logic        drp_den,
    output logic        drp_dwe,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    input  logic        mmcm_locked,
    output logic        mmcm_rst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cur_pal
);

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_ASSERT  = 4'd1;
    localparam logic [3:0] c_RD      = 4'd2;
    localparam logic [3:0] c_WRD     = 4'd3;
    localparam logic [3:0] c_WR      = 4'd4;
    localparam logic [3:0] c_WWR     = 4'd5;
    localparam logic [3:0] c_RELEASE = 4'd6;
    localparam logic [3:0] c_WLOCK   = 4'd7;
    localparam logic [3:0] c_ERR     = 4'd8;

    localparam int c_TMO_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int c_TMO_W   = $clog2(c_TMO_MAX + 1);
    localparam logic [c_TMO_W-1:0] c_DRDY_LAST = c_TMO_W'(DRDY_TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_LOCK_LAST = c_TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]         c_NREG      = 4'(NUM_REGS);

    logic [3:0]         r_state;
    logic [3:0]         r_idx;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_tgt;
    logic [6:0]         r_daddr;
    logic [15:0]        r_di;
    logic               r_mmcm_rst;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               r_cur_pal;

    // Tables padded to the full 4-bit index range; unused slots read as zero.
    logic [38:0] w_pal_tab  [16];
    logic [38:0] w_ntsc_tab [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_tab
        if (gi < NUM_REGS) begin : g_used
            assign w_pal_tab[gi]  = PAL_TABLE[gi*39 +: 39];
            assign w_ntsc_tab[gi] = NTSC_TABLE[gi*39 +: 39];
        end else begin : g_pad
            assign w_pal_tab[gi]  = '0;
            assign w_ntsc_tab[gi] = '0;
        end
    end

    logic [38:0] w_entry;
    logic [6:0]  w_addr;
    logic [15:0] w_mask;
    logic [15:0] w_data;

    assign w_entry = r_tgt ? w_pal_tab[r_idx] : w_ntsc_tab[r_idx];
    assign w_addr  = w_entry[38:32];
    assign w_mask  = w_entry[31:16];
    assign w_data  = w_entry[15:0];

    // idx advances on leaving WR, so in WWR it already points at the next entry.
    always_ff @(posedge clk_in12mhz) begin
        if (reset) begin
            r_state    <= c_RELEASE;
            r_idx      <= 4'd0;
            r_tmo      <= '0;
            r_tgt      <= INIT_PAL;
            r_daddr    <= 7'd0;
            r_di       <= 16'd0;
            r_mmcm_rst <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cur_pal  <= INIT_PAL;
        end else begin
            r_done <= 1'b0;
            r_tmo  <= '0;
            case (r_state)
                c_IDLE: begin
                    if (switch_req) begin
                        r_tgt      <= pal_sel;
                        r_error    <= 1'b0;
                        r_idx      <= 4'd0;
                        r_busy     <= 1'b1;
                        r_mmcm_rst <= 1'b1;
                        r_state    <= c_ASSERT;
                    end
                end
                c_ASSERT: begin
                    r_daddr <= w_addr;
                    r_state <= c_RD;
                end
                c_RD: r_state <= c_WRD;
                c_WRD: begin
                    if (drp_drdy) begin
                        r_di    <= (drp_do & ~w_mask) | (w_data & w_mask);
                        r_state <= c_WR;
                    end else if (r_tmo == c_DRDY_LAST) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ERR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_WR: begin
                    r_idx   <= r_idx + 4'd1;
                    r_state <= c_WWR;
                end
                c_WWR: begin
                    if (drp_drdy) begin
                        if (r_idx < c_NREG) begin
                            r_daddr <= w_addr;
                            r_state <= c_RD;
                        end else begin
                            r_state <= c_RELEASE;
                        end
                    end else if (r_tmo == c_DRDY_LAST) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ERR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_RELEASE: begin
                    r_mmcm_rst <= 1'b0;
                    r_state    <= c_WLOCK;
                end
                c_WLOCK: begin
                    if (mmcm_locked) begin
                        r_cur_pal <= r_tgt;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= c_IDLE;
                    end else if (r_tmo == c_LOCK_LAST) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ERR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_ERR:   r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign drp_den   = (r_state == c_RD) || (r_state == c_WR);
    assign drp_dwe   = (r_state == c_WR);
    assign drp_daddr = r_daddr;
    assign drp_di    = r_di;
    assign mmcm_rst  = r_mmcm_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign cur_pal   = r_cur_pal;

endmodule
`default_nettype wire

// File: doc/mmcm_std_reconfig.md
Name: mmcm_std_reconfig

Overview:
- DRP controller that reprograms the dot4x MMCM between PAL and NTSC multiply/divide settings at runtime, without a bitstream reload.
- Sits between the config register file and the MMCM DRP port. Runs on the MMCM's 12 MHz input clock, which is also used as DCLK.
- Sequence: hold the MMCM in reset, read-modify-write a table of DRP registers, release reset, wait for LOCKED.

Parameters:
- NUM_REGS, 8: DRP registers rewritten per switch (1..15).
- PAL_TABLE, all zero: NUM_REGS packed entries of {addr[6:0], mask[15:0], data[15:0]}, 39 bits each. Entry 0 occupies the LSBs. The top level supplies the real values.
- NTSC_TABLE, all zero: same format, NTSC values.
- DRDY_TIMEOUT, 64: cycles to wait for drdy before flagging an error.
- LOCK_TIMEOUT, 65535: cycles to wait for locked before flagging an error.
- INIT_PAL, 1: standard the MMCM holds at configuration time.

Ports:
- clk_in12mhz  in  1  clock for the controller and for MMCM DCLK
- reset  in  1  synchronous, active-high
- switch_req  in  1  single-cycle request to switch standard
- pal_sel  in  1  target standard (1=PAL, 0=NTSC), sampled together with switch_req
- drp_daddr  out  7  DRP address
- drp_di  out  16  DRP write data
- drp_den  out  1  DRP enable, one-cycle pulse
- drp_dwe  out  1  DRP write enable, qualified by drp_den
- drp_do  in  16  DRP read data
- drp_drdy  in  1  DRP ready
- mmcm_locked  in  1  MMCM LOCKED
- mmcm_rst  out  1  MMCM RST
- busy  out  1  high from request acceptance until DONE or ERR
- done  out  1  one-cycle pulse on successful lock
- error  out  1  sticky; cleared by reset or by the next accepted request
- cur_pal  out  1  standard last successfully programmed

Behaviour:
- Reset values:
  - mmcm_rst=1; drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0.
  - busy=1, done=0, error=0, cur_pal=INIT_PAL.
  - State RELEASE.
- States and transitions:
  - IDLE: busy=0. switch_req=1 latches pal_sel into tgt, clears error, sets idx=0, goes to ASSERT. Requests in any other state are ignored.
  - ASSERT: mmcm_rst=1, then go to RD.
  - RD: drp_den=1 and drp_dwe=0 for exactly one cycle, drp_daddr=table[tgt][idx].addr, then go to WRD.
  - WRD: on drp_drdy, latch rd=drp_do and go to WR. If the timeout counter reaches DRDY_TIMEOUT, go to ERR.
  - WR: drp_den=1 and drp_dwe=1 for one cycle, same addr, drp_di=(rd & ~mask) | (data & mask). Go to WWR.
  - WWR: on drp_drdy, go to RD with idx+1 if idx<NUM_REGS-1, else RELEASE. Timeout goes to ERR.
  - RELEASE: mmcm_rst=0, then go to WLOCK.
  - WLOCK: on mmcm_locked=1, set cur_pal=tgt, pulse done for 1 cycle, go to IDLE. If LOCK_TIMEOUT is reached, go to ERR.
  - ERR: error=1, mmcm_rst stays at its value at the time of entry, busy=0, go to IDLE.
- After reset, tgt=cur_pal. RELEASE and WLOCK run, then done pulses once.
- mmcm_rst stays high continuously from ASSERT through the last WWR.
- Timeout counters clear on every state entry. Only one DRP transaction is ever outstanding.
- drdy arriving outside WRD/WWR is ignored.
- Latency: exactly one cycle from an accepted switch_req to ASSERT, and one more to the first drp_den. drp_den may be driven combinationally from state or registered; either way it is a one-cycle pulse.
- Reset mid-operation: abort immediately and return to reset values. The MMCM is left in reset for one cycle, then relocks with whatever partially written table is present. cur_pal is not updated.
- switch_req with pal_sel==cur_pal is still fully executed, which makes it idempotent.
- Table index is 4 bits wide. Entries at idx>=NUM_REGS are never accessed.

Test Plan:
- Reset release with mmcm_locked rising 10 cycles later -> mmcm_rst falls on cycle 1; done pulses once; busy=0; cur_pal=1.
- NUM_REGS=2, request pal_sel=0, DRP model answers drdy 3 cycles after each den, entry0 mask=16'h0FFF data=16'h0123, readback 16'hA5A5 -> writes 16'hA123. Expect 4 den pulses, mmcm_rst high throughout, then done, cur_pal=0.
- DRP model never asserts drdy on the first read -> after 64 cycles error=1, busy=0, no write issued, cur_pal unchanged.
- mmcm_locked held low after the writes -> error after 65535 cycles. The next request clears error and completes normally.
- switch_req pulsed while busy, plus a spurious drdy in WLOCK -> no extra DRP accesses, one done only.
- reset asserted during WWR of entry 1 -> next cycle drp_den=0, mmcm_rst=1, busy=1; sequence recovers via RELEASE/WLOCK.
